// File: rtl/bcd_inc_arbiter_if.sv
// Request/load/tally bundle for bcd_inc_arbiter.
// The master drives requests and loads; the slave (the arbiter) returns the tally and the status pulses.
interface bcd_inc_arbiter_if;
  logic        req_a;
  logic        req_b;
  logic        load;
  logic [11:0] load_val;
  logic        clr_ovf;
  logic [11:0] count;
  logic        gnt_a;
  logic        gnt_b;
  logic        ovf;
  logic        err;

  modport master (
    output req_a, req_b, load, load_val, clr_ovf,
    input  count, gnt_a, gnt_b, ovf, err
  );

  modport slave (
    input  req_a, req_b, load, load_val, clr_ovf,
    output count, gnt_a, gnt_b, ovf, err
  );
endinterface

// File: rtl/bcd_inc_arbiter.sv
// Three-digit BCD tally with one shared incrementer.
// Two requesters share the incrementer under round-robin arbitration; a synchronous load has priority over both.
module bcd_inc_arbiter #(
  parameter bit SATURATE = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  bcd_inc_arbiter_if.slave  bus
);

  typedef enum logic {LAST_A, LAST_B} last_t;

  last_t       last_q, last_d;
  logic [11:0] count_q, count_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic [3:0]  d0, d1, d2;
  logic [3:0]  n0, n1, n2;
  logic        c0, c1, inc_ovf;
  logic [11:0] inc_val;
  logic        load_ok;

  // Shared BCD incrementer
  always_comb begin
    d0      = count_q[3:0];
    d1      = count_q[7:4];
    d2      = count_q[11:8];
    c0      = (d0 == 4'd9);
    c1      = c0 && (d1 == 4'd9);
    inc_ovf = c1 && (d2 == 4'd9);
    n0      = c0 ? 4'd0 : d0 + 4'd1;
    n1      = c0 ? ((d1 == 4'd9) ? 4'd0 : d1 + 4'd1) : d1;
    n2      = c1 ? ((d2 == 4'd9) ? 4'd0 : d2 + 4'd1) : d2;
    if (inc_ovf && SATURATE)
      inc_val = 12'h999;
    else
      inc_val = {n2, n1, n0};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= LAST_B;
      count_q <= '0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      count_q <= count_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state: load beats increment beats hold
  always_comb begin
    load_ok = (bus.load_val[3:0] <= 4'd9) && (bus.load_val[7:4] <= 4'd9) &&
              (bus.load_val[11:8] <= 4'd9);
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    err_d   = 1'b0;
    count_d = count_q;
    last_d  = last_q;
    ovf_d   = ovf_q && !bus.clr_ovf;

    if (bus.load) begin
      err_d = !load_ok;
      if (load_ok)
        count_d = bus.load_val;
    end else begin
      if (bus.req_a && bus.req_b) begin
        gnt_a_d = (last_q == LAST_B);
        gnt_b_d = (last_q == LAST_A);
      end else begin
        gnt_a_d = bus.req_a;
        gnt_b_d = bus.req_b;
      end
      if (gnt_a_d || gnt_b_d) begin
        count_d = inc_val;
        last_d  = gnt_a_d ? LAST_A : LAST_B;
        if (inc_ovf)
          ovf_d = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.count = count_q;
    bus.gnt_a = gnt_a_q;
    bus.gnt_b = gnt_b_q;
    bus.ovf   = ovf_q;
    bus.err   = err_q;
  end

endmodule

// File: tb/tb_bcd_inc_arbiter.sv
// Directed bench for bcd_inc_arbiter: a wrapping and a saturating instance share one stimulus stream.
module tb_bcd_inc_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_inc_arbiter_if ifw ();
  bcd_inc_arbiter_if ifs ();

  assign ifs.req_a    = ifw.req_a;
  assign ifs.req_b    = ifw.req_b;
  assign ifs.load     = ifw.load;
  assign ifs.load_val = ifw.load_val;
  assign ifs.clr_ovf  = ifw.clr_ovf;

  bcd_inc_arbiter #(.SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw));
  bcd_inc_arbiter #(.SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));

  typedef struct {
    logic        load;
    logic [11:0] load_val;
    logic        req_a;
    logic        req_b;
    logic        clr_ovf;
    logic [11:0] cnt_w;
    logic [11:0] cnt_s;
    logic        ga;
    logic        gb;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic [11:0] lv, input logic ra,
                       input logic rb, input logic co);
    ifw.load     = ld;
    ifw.load_val = lv;
    ifw.req_a    = ra;
    ifw.req_b    = rb;
    ifw.clr_ovf  = co;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] cw, input logic [11:0] cs,
                         input logic ga, input logic gb, input logic ov, input logic er);
    chk({tag, ".count_w"}, {20'd0, ifw.count}, {20'd0, cw});
    chk({tag, ".count_s"}, {20'd0, ifs.count}, {20'd0, cs});
    chk({tag, ".gnt_a"},   {31'd0, ifw.gnt_a}, {31'd0, ga});
    chk({tag, ".gnt_b"},   {31'd0, ifw.gnt_b}, {31'd0, gb});
    chk({tag, ".ovf_w"},   {31'd0, ifw.ovf},   {31'd0, ov});
    chk({tag, ".ovf_s"},   {31'd0, ifs.ovf},   {31'd0, ov});
    chk({tag, ".err"},     {31'd0, ifw.err},   {31'd0, er});
    chk({tag, ".excl"},
        {31'd0, (ifw.gnt_a & ifw.gnt_b) | (ifw.err & (ifw.gnt_a | ifw.gnt_b))}, 32'd0);
  endtask

  initial begin
    // load, load_val, req_a, req_b, clr_ovf | cnt_w, cnt_s, ga, gb, ovf, err
    vecs.push_back('{1'b1, 12'h280, 1'b0, 1'b0, 1'b0, 12'h280, 12'h280, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h281, 12'h281, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h281, 12'h281, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h289, 1'b0, 1'b0, 1'b0, 12'h289, 12'h289, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h290, 12'h290, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h299, 1'b0, 1'b0, 1'b0, 12'h299, 12'h299, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h300, 12'h300, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h967, 1'b0, 1'b0, 1'b0, 12'h967, 12'h967, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h968, 12'h968, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h001, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h002, 12'h002, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h003, 12'h003, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h004, 12'h004, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h999, 1'b0, 1'b0, 1'b0, 12'h999, 12'h999, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000, 12'h999, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h999, 1'b0, 1'b0, 1'b0, 12'h999, 12'h999, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000, 12'h999, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 12'h999, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h2A0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h999, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h999, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h555, 1'b1, 1'b0, 1'b0, 12'h555, 12'h555, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h555, 12'h555, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h556, 12'h556, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h09F, 1'b0, 1'b1, 1'b0, 12'h556, 12'h556, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h557, 12'h557, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h558, 12'h558, 1'b0, 1'b1, 1'b0, 1'b0});

    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    #1;
    chk_all("reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    #12 rst_n = 1'b1;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].load_val, vecs[i].req_a, vecs[i].req_b, vecs[i].clr_ovf);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].cnt_w, vecs[i].cnt_s,
              vecs[i].ga, vecs[i].gb, vecs[i].ovf, vecs[i].err);
    end

    // Uninterrupted burst from A, then asynchronous reset mid-burst
    drive(1'b1, 12'h148, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("burst1", 12'h149, 12'h149, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("burst2", 12'h150, 12'h150, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("burst3", 12'h151, 12'h151, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    ifw.req_b = 1'b1;
    step();
    chk_all("held_rst", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    step();
    chk_all("post_rst1", 12'h001, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("post_rst2", 12'h002, 12'h002, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("idle", 12'h002, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
